zap_decode_irq_seq: RTL and testbench

ZAP_DECODE_IRQ_SEQ -- requirements
Module: zap_decode_irq_seq

---
 rtl/zap_decode_irq_seq.sv | 129 ++++++++++++
 tb/tb_zap_decode_irq_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/zap_decode_irq_seq.sv
// Interrupt injection sequencer between fetch and decode.
// Takes a registered, unmasked FIQ/IRQ, injects one synthetic instruction,
// then holds fetch in WAIT until a bounded number of advancing cycles pass
// or the pipeline is flushed.
module zap_decode_irq_seq #(
    parameter logic [34:0] FIQ_INSTR = 35'h0_EB00_0007,
    parameter logic [34:0] IRQ_INSTR = 35'h0_EB00_0006,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [34:0] i_instruction,
    input  logic        i_instruction_valid,
    input  logic        i_irq,
    input  logic        i_fiq,
    input  logic        i_cpsr_i,
    input  logic        i_cpsr_f,
    input  logic        i_stall_from_decode,
    input  logic        i_clear_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_clear_from_alu,
    input  logic        i_stall_from_shifter,
    input  logic        i_issue_stall,
    output logic [34:0] o_instruction,
    output logic        o_instruction_valid,
    output logic        o_hold_fetch,
    output logic        o_fiq_taken,
    output logic        o_irq_taken,
    output logic        o_timeout
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_INJECT = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sel_fiq;
    logic             sel_fiq_nxt;
    logic             pend_fiq;
    logic             pend_irq;
    logic             advance;
    logic             clear;

    // Pipeline control decode: clears only win over holds that rank below them.
    assign advance = ~(i_reset | i_clear_from_writeback | i_data_stall |
                       i_clear_from_alu | i_stall_from_shifter | i_issue_stall);
    assign clear   = i_reset | i_clear_from_writeback |
                     (~i_data_stall & i_clear_from_alu);

    // State, counter, frozen selection and pending-interrupt registers.
    always_ff @(posedge i_clk) begin
        if (clear) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sel_fiq  <= 1'b0;
            pend_fiq <= 1'b0;
            pend_irq <= 1'b0;
        end else if (advance) begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sel_fiq  <= sel_fiq_nxt;
            pend_fiq <= i_fiq & ~i_cpsr_f;
            pend_irq <= i_irq & ~i_cpsr_i;
        end
    end

    // Next-state logic, only applied on advancing cycles.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        sel_fiq_nxt = sel_fiq;
        case (state)
            S_IDLE: begin
                if ((pend_fiq | pend_irq) & i_instruction_valid & ~i_stall_from_decode) begin
                    state_nxt   = S_INJECT;
                    sel_fiq_nxt = pend_fiq;
                end
            end
            S_INJECT: begin
                state_nxt = S_WAIT;
                cnt_nxt   = '0;
            end
            S_WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode: pass-through in IDLE, injected instruction in INJECT.
    always_comb begin
        o_instruction       = i_instruction;
        o_instruction_valid = i_instruction_valid;
        o_hold_fetch        = 1'b0;
        o_fiq_taken         = 1'b0;
        o_irq_taken         = 1'b0;
        o_timeout           = 1'b0;
        case (state)
            S_INJECT: begin
                o_instruction       = sel_fiq ? FIQ_INSTR : IRQ_INSTR;
                o_instruction_valid = 1'b1;
                o_hold_fetch        = 1'b1;
                o_fiq_taken         = advance & sel_fiq;
                o_irq_taken         = advance & ~sel_fiq;
            end
            S_WAIT: begin
                o_instruction_valid = 1'b0;
                o_hold_fetch        = 1'b1;
                o_timeout           = advance & (cnt == CNT_LAST);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_zap_decode_irq_seq.sv
// Randomized bench for zap_decode_irq_seq against a behavioural model.
module tb_zap_decode_irq_seq;

    localparam logic [34:0] FIQ_I = 35'h0_EB00_0007;
    localparam logic [34:0] IRQ_I = 35'h0_EB00_0006;
    localparam int          TMO   = 15;

    logic        clk = 1'b0;
    logic        rst, ivalid, irq, fiq, cpsr_i, cpsr_f, sdec;
    logic        cwb, dstall, calu, sshift, istall;
    logic [34:0] instr;
    logic [34:0] o_instr;
    logic        o_valid, o_hold, o_fiq_tk, o_irq_tk, o_tmo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    zap_decode_irq_seq #(
        .FIQ_INSTR(FIQ_I),
        .IRQ_INSTR(IRQ_I),
        .TIMEOUT  (TMO)
    ) dut (
        .i_clk                 (clk),
        .i_reset               (rst),
        .i_instruction         (instr),
        .i_instruction_valid   (ivalid),
        .i_irq                 (irq),
        .i_fiq                 (fiq),
        .i_cpsr_i              (cpsr_i),
        .i_cpsr_f              (cpsr_f),
        .i_stall_from_decode   (sdec),
        .i_clear_from_writeback(cwb),
        .i_data_stall          (dstall),
        .i_clear_from_alu      (calu),
        .i_stall_from_shifter  (sshift),
        .i_issue_stall         (istall),
        .o_instruction         (o_instr),
        .o_instruction_valid   (o_valid),
        .o_hold_fetch          (o_hold),
        .o_fiq_taken           (o_fiq_tk),
        .o_irq_taken           (o_irq_tk),
        .o_timeout             (o_tmo)
    );

    task automatic check_eq(input string tag, input logic [34:0] got, input logic [34:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: busy = 0 idle, 1 injecting, 1+k = k-th WAIT cycle (k from 1).
    int   busy;
    bit   m_pf, m_pi, m_sel;
    int   n_take, n_tmo;

    function automatic bit rnd(input int one_in);
        return ($urandom_range(one_in - 1, 0) == 0);
    endfunction

    task automatic drive(input int quiet);
        rst    = rnd(quiet ? 400 : 60);
        cwb    = rnd(quiet ? 400 : 40);
        calu   = rnd(quiet ? 400 : 40);
        dstall = rnd(quiet ? 12 : 7);
        sshift = rnd(quiet ? 40 : 15);
        istall = rnd(quiet ? 40 : 15);
        irq    = rnd(3);
        fiq    = rnd(4);
        cpsr_i = rnd(4);
        cpsr_f = rnd(4);
        sdec   = rnd(5);
        ivalid = !rnd(4);
        instr  = {3'($urandom_range(7, 0)), 32'($urandom)};
    endtask

    task automatic check_outputs();
        bit adv;
        adv = !(rst || cwb || dstall || calu || sshift || istall);
        if (busy == 0) begin
            check_eq("idle_instr", o_instr, instr);
            check_eq("idle_valid", 35'(o_valid), 35'(ivalid));
            check_eq("idle_hold", 35'(o_hold), 35'd0);
            check_eq("idle_fiq_tk", 35'(o_fiq_tk), 35'd0);
            check_eq("idle_irq_tk", 35'(o_irq_tk), 35'd0);
            check_eq("idle_tmo", 35'(o_tmo), 35'd0);
        end else if (busy == 1) begin
            check_eq("inj_instr", o_instr, m_sel ? FIQ_I : IRQ_I);
            check_eq("inj_valid", 35'(o_valid), 35'd1);
            check_eq("inj_hold", 35'(o_hold), 35'd1);
            check_eq("inj_fiq_tk", 35'(o_fiq_tk), 35'(adv && m_sel));
            check_eq("inj_irq_tk", 35'(o_irq_tk), 35'(adv && !m_sel));
            check_eq("inj_tmo", 35'(o_tmo), 35'd0);
            if (adv) n_take++;
        end else begin
            check_eq("wait_valid", 35'(o_valid), 35'd0);
            check_eq("wait_hold", 35'(o_hold), 35'd1);
            check_eq("wait_fiq_tk", 35'(o_fiq_tk), 35'd0);
            check_eq("wait_irq_tk", 35'(o_irq_tk), 35'd0);
            check_eq("wait_tmo", 35'(o_tmo), 35'(adv && (busy - 1 == TMO)));
            if (adv && (busy - 1 == TMO)) n_tmo++;
        end
    endtask

    task automatic model_step();
        bit adv, clr;
        adv = !(rst || cwb || dstall || calu || sshift || istall);
        clr = rst || cwb || (!dstall && calu);
        if (clr) begin
            busy = 0;
            m_pf = 0;
            m_pi = 0;
        end else if (adv) begin
            if (busy == 0) begin
                if ((m_pf || m_pi) && ivalid && !sdec) begin
                    busy  = 1;
                    m_sel = m_pf;
                end
            end else if (busy - 1 == TMO) begin
                busy = 0;
            end else begin
                busy = busy + 1;
            end
            m_pf = fiq && !cpsr_f;
            m_pi = irq && !cpsr_i;
        end
    endtask

    initial begin
        busy = 0; m_pf = 0; m_pi = 0; m_sel = 0; n_take = 0; n_tmo = 0;
        drive(0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            drive(c >= 3000);
            if (c == 0) rst = 1'b0;
            #1;
            check_outputs();
            @(posedge clk);
            model_step();
        end
        check_eq("saw_takes", 35'(n_take > 20), 35'd1);
        check_eq("saw_timeouts", 35'(n_tmo > 2), 35'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
